// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM encoding
// and parameter legality helpers.
package serial_adder_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic bit digit_cfg_ok(input int width, input int digit);
        return (digit inside {1, 2, 4, 8, 16}) && (width >= digit) && (width % digit == 0);
    endfunction

    // A single-step build still needs a one-bit counter to stay well-formed.
    function automatic int cnt_bits(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle for serial_adder; the requester owns start and the
// operands, the adder owns status and the held result.
interface serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple of full adders; also exposes the carry into
// the top bit so the caller can form signed overflow.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             ci_i,
    output logic [DIGIT-1:0] s_o,
    output logic             co_o,
    output logic             c_msb_o
);
    always_comb begin
        logic c;
        c       = ci_i;
        c_msb_o = ci_i;
        s_o     = '0;
        for (int i = 0; i < DIGIT; i++) begin
            c_msb_o = c;
            s_o[i]  = a_i[i] ^ b_i[i] ^ c;
            c       = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
        end
        co_o = c;
    end
endmodule

// File: rtl/serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: DIGIT bits per clock, LSD first,
// with a registered carry between digits and a separately held result.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input logic          clk,
    input logic          rst,
    serial_adder_if.slave bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = cnt_bits(STEPS);

    if (!digit_cfg_ok(WIDTH, DIGIT)) begin : g_bad_cfg
        $error("serial_adder: illegal WIDTH/DIGIT combination");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d, sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, done_q, done_d;

    logic [DIGIT-1:0] dig_s;
    logic             dig_co, dig_cmsb;
    logic [WIDTH-1:0] dig_ext, work_shift;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a_i     (a_q[DIGIT-1:0]),
        .b_i     (b_q[DIGIT-1:0]),
        .ci_i    (carry_q),
        .s_o     (dig_s),
        .co_o    (dig_co),
        .c_msb_o (dig_cmsb)
    );

    // Each new digit enters the working register at the top, so after STEPS
    // shifts the first digit has reached bit 0.
    assign dig_ext    = WIDTH'(dig_s);
    assign work_shift = (work_q >> DIGIT) | (dig_ext << (WIDTH - DIGIT));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b ^ {WIDTH{bus.sub}};
                    carry_d = bus.sub | bus.cin;
                    cnt_d   = '0;
                    work_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dig_co;
                work_d  = work_shift;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(STEPS - 1)) begin
                    sum_d   = work_shift;
                    cout_d  = dig_co;
                    ovf_d   = dig_co ^ dig_cmsb;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            work_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy     = (state_q == ST_RUN);
    assign bus.done     = done_q;
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three builds (DIGIT=1, 4, 16) side by side against
// an arithmetic reference model, with directed and random operations.
module tb_serial_adder;
    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]   st    = '0;
    logic [W-1:0] a_s   = '0;
    logic [W-1:0] b_s   = '0;
    logic         cin_s = 1'b0;
    logic         sub_s = 1'b0;

    serial_adder_if #(.WIDTH(W)) if1 ();
    serial_adder_if #(.WIDTH(W)) if4 ();
    serial_adder_if #(.WIDTH(W)) if16 ();

    serial_adder #(.WIDTH(W), .DIGIT(1))  u_d1  (.clk(clk), .rst(rst), .bus(if1));
    serial_adder #(.WIDTH(W), .DIGIT(4))  u_d4  (.clk(clk), .rst(rst), .bus(if4));
    serial_adder #(.WIDTH(W), .DIGIT(16)) u_d16 (.clk(clk), .rst(rst), .bus(if16));

    assign if1.start  = st[0];  assign if1.a  = a_s; assign if1.b  = b_s;
    assign if1.cin    = cin_s;  assign if1.sub  = sub_s;
    assign if4.start  = st[1];  assign if4.a  = a_s; assign if4.b  = b_s;
    assign if4.cin    = cin_s;  assign if4.sub  = sub_s;
    assign if16.start = st[2];  assign if16.a = a_s; assign if16.b = b_s;
    assign if16.cin   = cin_s;  assign if16.sub = sub_s;

    logic [2:0]   busy_w, done_w, cout_w, ovf_w;
    logic [W-1:0] sum_w [3];
    assign busy_w = {if16.busy, if4.busy, if1.busy};
    assign done_w = {if16.done, if4.done, if1.done};
    assign cout_w = {if16.cout, if4.cout, if1.cout};
    assign ovf_w  = {if16.overflow, if4.overflow, if1.overflow};
    assign sum_w[0] = if1.sum;
    assign sum_w[1] = if4.sum;
    assign sum_w[2] = if16.sum;

    int   total = 0;
    int   bad   = 0;
    int   steps_k [3] = '{16, 4, 1};
    bit   pending [3];
    int   n       [3];
    res_t exp_r   [3];
    res_t last_r  [3];

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        res_t         r;
        logic [W:0]   full;
        int           sr;
        if (sub) begin
            r.s = a - b;
            r.c = (a >= b);
            sr  = int'($signed(a)) - int'($signed(b));
        end else begin
            full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            r.s  = full[W-1:0];
            r.c  = full[W];
            sr   = int'($signed(a)) + int'($signed(b)) + int'(cin);
        end
        r.v = (sr > (2**(W-1)) - 1) || (sr < -(2**(W-1)));
        return r;
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s[dut%0d] observed=%0h expected=%0h", tag, k, obs, expv);
        end
    endtask

    // One clock: release start, then score every build at the sample point.
    task automatic step();
        @(posedge clk);
        #1;
        st = '0;
        for (int k = 0; k < 3; k++) begin
            if (pending[k]) n[k]++;
            if (done_w[k]) begin
                if (!pending[k]) begin
                    chk("spurious_done", k, 32'(done_w[k]), 32'(1'b0));
                end else begin
                    chk("latency", k, 32'(n[k]), 32'(steps_k[k]));
                    chk("result", k, 32'({sum_w[k], cout_w[k], ovf_w[k]}), 32'(exp_r[k]));
                    last_r[k]  = exp_r[k];
                    pending[k] = 1'b0;
                end
            end else begin
                if (pending[k] && n[k] > steps_k[k]) begin
                    chk("done_timeout", k, 32'(n[k]), 32'(steps_k[k]));
                    pending[k] = 1'b0;
                end
                chk("hold", k, 32'({sum_w[k], cout_w[k], ovf_w[k]}), 32'(last_r[k]));
            end
            chk("busy", k, 32'(busy_w[k]), 32'(pending[k]));
        end
    endtask

    task automatic launch(input logic [2:0] mask, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
        a_s = a; b_s = b; cin_s = cin; sub_s = sub;
        st  = mask;
        for (int k = 0; k < 3; k++) begin
            if (mask[k]) begin
                exp_r[k]   = model(a, b, cin, sub);
                pending[k] = 1'b1;
                n[k]       = -1;
            end
        end
    endtask

    task automatic scramble();
        a_s   = W'($urandom);
        b_s   = W'($urandom);
        cin_s = 1'($urandom);
        sub_s = 1'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (pending[0] || pending[1] || pending[2]); i++) step();
    endtask

    task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                            input logic sub, input logic [W-1:0] es, input logic ec, input logic ev);
        launch(3'b111, a, b, cin, sub);
        step();
        scramble();
        drain();
        for (int k = 0; k < 3; k++)
            chk("vector", k, 32'({sum_w[k], cout_w[k], ovf_w[k]}), 32'({es, ec, ev}));
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk({tag, "_busy"}, k, 32'(busy_w[k]), 32'(1'b0));
            chk({tag, "_done"}, k, 32'(done_w[k]), 32'(1'b0));
            chk({tag, "_out"},  k, 32'({sum_w[k], cout_w[k], ovf_w[k]}), 32'(0));
            pending[k] = 1'b0;
            last_r[k]  = '0;
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            pending[k] = 1'b0; n[k] = 0; exp_r[k] = '0; last_r[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        step();

        directed(16'h0000, 16'h0001, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0);
        directed(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        directed(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        directed(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        directed(16'h1234, 16'h4321, 1'b1, 1'b1, 16'hCF13, 1'b0, 1'b0);

        // A start pulsed mid-run must not disturb the operation in flight.
        launch(3'b001, 16'h1234, 16'h1111, 1'b0, 1'b0);
        repeat (5) step();
        a_s = 16'hFFFF; b_s = 16'hFFFF; cin_s = 1'b1; sub_s = 1'b1;
        st  = 3'b001;
        step();
        scramble();
        drain();
        chk("ignored_start", 0, 32'(sum_w[0]), 32'(16'h2345));

        // Back-to-back: the next start lands in the done cycle.
        launch(3'b001, 16'hABCD, 16'h1111, 1'b1, 1'b0);
        step();
        scramble();
        for (int i = 0; i < 40 && pending[0]; i++) step();
        launch(3'b001, 16'h0003, 16'h0009, 1'b0, 1'b1);
        step();
        scramble();
        drain();
        chk("b2b_second", 0, 32'({sum_w[0], cout_w[0]}), 32'({16'hFFFA, 1'b0}));

        // Asynchronous reset in the middle of an operation.
        launch(3'b111, 16'h0F0F, 16'h00FF, 1'b0, 1'b0);
        step();
        scramble();
        repeat (7) step();
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        step();
        step();
        rst = 1'b0;
        repeat (20) step();
        directed(16'h2222, 16'h1111, 1'b1, 1'b0, 16'h3334, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            launch(3'b111, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            step();
            scramble();
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Multi-cycle, parametrised adder/subtractor for the arith library.
- Processes a WIDTH-bit operand pair DIGIT bits per clock, least-significant digit first, with a registered carry between digits.
- Trades latency for area; the sequential successor to the single-bit adder cells.
- Used by the ALU/CPU datapath where a low-gate-count add is acceptable.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT
DIGIT, 1, bits added per clock (1 = pure bit-serial); legal values 1, 2, 4, 8, 16 with WIDTH % DIGIT == 0
STEPS, WIDTH/DIGIT, derived localparam: cycles per operation

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
start  in  1  request to begin an operation; sampled only when busy=0
sub  in  1  0: a+b+cin; 1: a-b (b inverted, carry-in forced 1, cin ignored)
a  in  WIDTH  operand A, latched on accepted start
b  in  WIDTH  operand B, latched on accepted start
cin  in  1  carry-in for add mode, latched on accepted start
busy  out  1  high while an operation is in progress
done  out  1  one-cycle pulse: sum/cout/overflow valid
sum  out  WIDTH  result, held until next done
cout  out  1  carry out of MSB; for sub, 1 = no borrow (a >= b unsigned)
overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (async, any time including mid-operation):
  - state=IDLE; busy=0, done=0, sum=0, cout=0, overflow=0.
  - Internal shift registers, carry and step counter cleared.
  - In-flight operation discarded; no done pulse.
- States: IDLE, RUN.
- IDLE, start=1 at edge k:
  - Latch a, b^{WIDTH{sub}}, and carry = sub ? 1 : cin.
  - Step counter=0; go to RUN.
  - busy=1 from after edge k.
- RUN, each edge:
  - digit = low DIGIT bits of A + low DIGIT bits of B' + carry.
  - Shift the result digit into the sum register from the top; shift A/B' right by DIGIT; carry <= digit carry-out.
  - Counter increments.
  - On the edge where counter == STEPS-1:
    - Register final sum, cout = final carry, overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
    - done=1 for exactly the following cycle; busy=0; state=IDLE.
- Latency: start accepted at edge k -> done high in the cycle after edge k+STEPS.
  - DIGIT=1, WIDTH=16: 16 cycles.
  - DIGIT=4: 4 cycles.
  - DIGIT=WIDTH: 1 cycle.
- Start handling:
  - start while busy=1: ignored, with no effect on operands or result.
  - start in the cycle done=1: accepted, giving back-to-back operation; done falls next cycle and busy rises.
- Input timing: a/b/cin/sub may change freely after the accepting edge.
- Output hold: sum/cout/overflow hold the last result until the next completion; not updated during RUN.
  - The working sum register is separate from the output register, or equivalent gating is used.
- Arithmetic is modulo 2^WIDTH; no saturation.

Decomposition:
- Shared arith package/include:
  - state encodings (ST_IDLE, ST_RUN)
  - legality check macro for WIDTH % DIGIT
- One natural sub-module: digit_adder #(DIGIT).
  - Combinational ripple of full adders.
  - Inputs a[DIGIT], b[DIGIT], ci; outputs s[DIGIT], co, c_msb (carry into top bit, for overflow).
- serial_adder holds the FSM, counter, shift registers and output registers.

Test Plan:
- WIDTH=16, DIGIT=1: reset, then start with a=0x0000, b=0x0001, cin=0, sub=0 -> done exactly 16 cycles after the start edge; sum=0x0001, cout=0, overflow=0; done high 1 cycle.
- a=0xFFFF, b=0x0001, add -> sum=0x0000, cout=1, overflow=0.
- a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, overflow=1.
- sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, overflow=0.
- sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, overflow=1.
- Start pulsed at cycle 5 of a running op with different operands -> ignored; first result unchanged.
- Start asserted in the done cycle -> second op completes 16 cycles later.
- rst asserted at cycle 8 of an op -> all outputs 0 immediately, no done pulse; a fresh op afterward is correct.
- DIGIT=4 and DIGIT=16 builds:
  - a=0x1234, b=0x4321, cin=1 -> sum=0x5556.
  - Latency 4 and 1 cycles respectively.
  - Random 1000-vector sweep vs behavioural a+b+cin / a-b model.
